// File: rtl/fifo_sync_pkg.sv
// Shared types, widths and flag helpers for the fwft fifo.
// Optional watermark build: FIFO_SYNC_WATERMARK_EN.
package fifo_sync_pkg;

  localparam logic AE_RST = 1'b1;
  localparam logic AF_RST = 1'b0;

  typedef enum logic {
    CMP_LE,
    CMP_GE
  } cmp_e;

  function automatic int cnt_w(input int dl);
    return dl + 1;
  endfunction

  function automatic logic thr_cmp(
    input logic [15:0] a,
    input logic [15:0] b,
    input cmp_e op
  );
    return (op == CMP_GE) ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Pointers, occupancy, fwft pipeline valids and status flags.
// FIFO_SYNC_WATERMARK_EN adds the high-watermark register.
module fifo_sync_ptr
  import fifo_sync_pkg::*;
#(
  parameter int DEPTH_LOG = 9,
  parameter int CW = cnt_w(DEPTH_LOG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_wr_en,
  input  logic                 i_rd_en,
  input  logic [CW-1:0]        i_af_thresh,
  input  logic [CW-1:0]        i_ae_thresh,
  output logic                 o_wr_ok,
  output logic [DEPTH_LOG-1:0] o_wr_addr,
  output logic                 o_re,
  output logic [DEPTH_LOG-1:0] o_rd_addr,
  output logic                 o_load,
  output logic                 o_full,
  output logic                 o_almost_full,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic [CW-1:0]        o_words,
  output logic [CW-1:0]        o_max_words
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int PW = DEPTH_LOG;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] unread;
  logic          s1_vld_q, s1_vld_d;
  logic          out_vld_q, out_vld_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          wr_ok, rd_ok, re, load;

  // s1 is the memory read register; out is the fwft head
  always_comb begin
    wr_ok = i_wr_en & ~full_q & ~i_flush;
    rd_ok = i_rd_en & out_vld_q & ~i_flush;
    unread = cnt_q - CW'(out_vld_q) - CW'(s1_vld_q);
    load = s1_vld_q & (~out_vld_q | rd_ok) & ~i_flush;
    re = (unread != '0) & (~s1_vld_q | load) & ~i_flush;
    wr_ptr_d = wr_ptr_q + PW'(wr_ok);
    rd_ptr_d = rd_ptr_q + PW'(re);
    cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
    s1_vld_d = re | (s1_vld_q & ~load);
    out_vld_d = load | (out_vld_q & ~rd_ok);
    full_d = (cnt_d == CW'(DEPTH));
    af_d = thr_cmp(16'(cnt_d), 16'(i_af_thresh), CMP_GE);
    ae_d = thr_cmp(16'(cnt_d), 16'(i_ae_thresh), CMP_LE);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d = '0;
      s1_vld_d = 1'b0;
      out_vld_d = 1'b0;
      full_d = 1'b0;
      af_d = AF_RST;
      ae_d = AE_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      s1_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      full_q <= 1'b0;
      af_q <= AF_RST;
      ae_q <= AE_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      s1_vld_q <= s1_vld_d;
      out_vld_q <= out_vld_d;
      full_q <= full_d;
      af_q <= af_d;
      ae_q <= ae_d;
    end
  end

`ifdef FIFO_SYNC_WATERMARK_EN
  logic [CW-1:0] max_q, max_d;

  always_comb begin
    max_d = (cnt_d > max_q) ? cnt_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else max_q <= max_d;
  end

  assign o_max_words = max_q;
`else
  assign o_max_words = '0;
`endif

  assign o_wr_ok = wr_ok;
  assign o_wr_addr = wr_ptr_q;
  assign o_re = re;
  assign o_rd_addr = rd_ptr_q;
  assign o_load = load;
  assign o_full = full_q;
  assign o_almost_full = af_q;
  assign o_empty = ~out_vld_q;
  assign o_almost_empty = ae_q;
  assign o_words = cnt_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock fwft fifo: inferred two-port ram plus head register.
// FIFO_SYNC_WATERMARK_EN enables the o_max_words watermark.
module fifo_sync_fwft
  import fifo_sync_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH_LOG = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic [DW-1:0]        i_wr_data,
  input  logic                 i_wr_en,
  output logic                 o_full,
  output logic                 o_almost_full,
  input  logic [DEPTH_LOG:0]   i_af_thresh,
  input  logic                 i_rd_en,
  output logic [DW-1:0]        o_rd_data,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  input  logic [DEPTH_LOG:0]   i_ae_thresh,
  output logic [DEPTH_LOG:0]   o_words,
  output logic [DEPTH_LOG:0]   o_max_words
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic                 wr_ok, re, load;
  logic [DEPTH_LOG-1:0] wr_addr, rd_addr;
  logic [DW-1:0]        mem_q [DEPTH];
  logic [DW-1:0]        mem_rd_q;
  logic [DW-1:0]        rd_data_q, rd_data_d;

  fifo_sync_ptr #(
    .DEPTH_LOG(DEPTH_LOG)
  ) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .i_wr_en       (i_wr_en),
    .i_rd_en       (i_rd_en),
    .i_af_thresh   (i_af_thresh),
    .i_ae_thresh   (i_ae_thresh),
    .o_wr_ok       (wr_ok),
    .o_wr_addr     (wr_addr),
    .o_re          (re),
    .o_rd_addr     (rd_addr),
    .o_load        (load),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_empty       (o_empty),
    .o_almost_empty(o_almost_empty),
    .o_words       (o_words),
    .o_max_words   (o_max_words)
  );

  // read register holds its word until the head stage takes it
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= i_wr_data;
    if (re) mem_rd_q <= mem_q[rd_addr];
  end

  always_comb begin
    rd_data_d = load ? mem_rd_q : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: queue model plus directed tests.
module tb_fifo_sync_fwft;

  localparam int DW = 16;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_flush = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_wr_en = 1'b0;
  logic          i_rd_en = 1'b0;
  logic [DL:0]   i_af_thresh = 5'd14;
  logic [DL:0]   i_ae_thresh = 5'd1;
  logic          o_full, o_almost_full, o_empty, o_almost_empty;
  logic [DW-1:0] o_rd_data;
  logic [DL:0]   o_words, o_max_words;

  fifo_sync_fwft #(.DW(DW), .DEPTH_LOG(DL)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .i_wr_data     (i_wr_data),
    .i_wr_en       (i_wr_en),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .i_af_thresh   (i_af_thresh),
    .i_rd_en       (i_rd_en),
    .o_rd_data     (o_rd_data),
    .o_empty       (o_empty),
    .o_almost_empty(o_almost_empty),
    .i_ae_thresh   (i_ae_thresh),
    .o_words       (o_words),
    .o_max_words   (o_max_words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [15:0] popped[$];
  int          e = 0;
  int          mx = 0;
  logic [15:0] rd_exp = '0;
  bit          started = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // head is visible two edges after its write
  function automatic bit vis();
    return q.size() > 0 && (e - q[0].t) >= 2;
  endfunction

  always @(posedge clk) begin
    bit rok, wok;
    rok = i_rd_en && vis();
    wok = i_wr_en && q.size() < 16;
    e++;
    if (rst) begin
      q.delete();
      rd_exp = '0;
      mx = 0;
    end else if (i_flush) begin
      q.delete();
    end else begin
      if (rok) begin
        popped.push_back(q[0].d);
        void'(q.pop_front());
      end
      if (wok) q.push_back('{i_wr_data, e});
    end
    if (vis()) rd_exp = q[0].d;
    if (q.size() > mx) mx = q.size();
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("words", int'(o_words), q.size());
      chk("full", int'(o_full), int'(q.size() == 16));
      chk("empty", int'(o_empty), int'(!vis()));
      chk("afull", int'(o_almost_full), int'(q.size() >= 14));
      chk("aempty", int'(o_almost_empty), int'(q.size() <= 1));
      chk("rd_data", int'(o_rd_data), int'(rd_exp));
`ifdef FIFO_SYNC_WATERMARK_EN
      chk("max_words", int'(o_max_words), mx);
`else
      chk("max_words", int'(o_max_words), 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int n;
    step();
    step();
    rst = 1'b0;
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_words", int'(o_words), 0);
    chk("rst_aempty", int'(o_almost_empty), 1);
    chk("rst_rd_data", int'(o_rd_data), 0);

    // single word fill latency
    i_wr_en = 1'b1;
    i_wr_data = 16'hA5A5;
    step();
    i_wr_en = 1'b0;
    chk("t1_words_e0", int'(o_words), 1);
    chk("t1_empty_e0", int'(o_empty), 1);
    step();
    chk("t1_empty_e1", int'(o_empty), 1);
    step();
    chk("t1_empty_e2", int'(o_empty), 0);
    chk("t1_data_e2", int'(o_rd_data), 16'hA5A5);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    chk("t1_empty_pop", int'(o_empty), 1);
    chk("t1_words_pop", int'(o_words), 0);

    // fill to full, overflow write dropped
    for (int i = 0; i < 16; i++) begin
      i_wr_en = 1'b1;
      i_wr_data = 16'(i);
      step();
      if (i == 12) chk("t2_afull_13", int'(o_almost_full), 0);
      if (i == 13) chk("t2_afull_14", int'(o_almost_full), 1);
      if (i == 14) chk("t2_full_15", int'(o_full), 0);
    end
    chk("t2_full", int'(o_full), 1);
    i_wr_data = 16'hFFFF;
    step();
    i_wr_en = 1'b0;
    chk("t2_words_ovf", int'(o_words), 16);
    popped.delete();
    i_rd_en = 1'b1;
    for (int k = 0; k < 40 && popped.size() < 16; k++) step();
    i_rd_en = 1'b0;
    chk("t2_npop", popped.size(), 16);
    bad = 0;
    for (int i = 0; i < popped.size(); i++)
      if (popped[i] != 16'(i)) bad++;
    chk("t2_order", bad, 0);

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) begin
      i_wr_en = 1'b1;
      i_wr_data = 16'(32 + i);
      step();
    end
    i_wr_en = 1'b0;
    step();
    step();
    popped.delete();
    i_wr_en = 1'b1;
    i_rd_en = 1'b1;
    i_wr_data = 16'h0100;
    step();
    i_wr_en = 1'b0;
    chk("t3_words", int'(o_words), 15);
    for (int k = 0; k < 60 && o_words != 0; k++) step();
    i_rd_en = 1'b0;
    chk("t3_npop", popped.size(), 16);
    bad = 0;
    for (int i = 0; i < popped.size(); i++)
      if (popped[i] == 16'h0100) bad++;
    chk("t3_no_0100", bad, 0);

    // streaming across wrap-around
    popped.delete();
    i_wr_en = 1'b1;
    i_rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      i_wr_data = 16'(100 + k);
      step();
    end
    i_wr_en = 1'b0;
    chk("t4_words", int'(o_words), 3);
    chk("t4_npop", popped.size(), 37);
    bad = 0;
    for (int i = 0; i < popped.size(); i++)
      if (popped[i] != 16'(100 + i)) bad++;
    chk("t4_order", bad, 0);
    for (int k = 0; k < 20 && o_words != 0; k++) step();
    i_rd_en = 1'b0;
    chk("t4_drained", int'(o_words), 0);

    // flush after filling to nine
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      i_wr_en = 1'b1;
      i_wr_data = 16'(200 + i);
      step();
    end
    i_flush = 1'b1;
    i_wr_data = 16'h7777;
    step();
    i_flush = 1'b0;
    i_wr_en = 1'b0;
    chk("t5_words", int'(o_words), 0);
    chk("t5_empty", int'(o_empty), 1);
    chk("t5_aempty", int'(o_almost_empty), 1);
`ifdef FIFO_SYNC_WATERMARK_EN
    chk("t5_max", int'(o_max_words), 9);
`else
    chk("t5_max", int'(o_max_words), 0);
`endif
    i_wr_en = 1'b1;
    i_wr_data = 16'h1234;
    step();
    i_wr_en = 1'b0;
    step();
    step();
    chk("t5_empty_rd", int'(o_empty), 0);
    chk("t5_data", int'(o_rd_data), 16'h1234);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;

    // reset with words queued and a pop pending
    for (int i = 0; i < 5; i++) begin
      i_wr_en = 1'b1;
      i_wr_data = 16'(300 + i);
      step();
    end
    i_wr_en = 1'b0;
    step();
    step();
    rst = 1'b1;
    i_rd_en = 1'b1;
    step();
    rst = 1'b0;
    i_rd_en = 1'b0;
    chk("t6_words", int'(o_words), 0);
    chk("t6_empty", int'(o_empty), 1);
    chk("t6_full", int'(o_full), 0);
    chk("t6_aempty", int'(o_almost_empty), 1);
    chk("t6_afull", int'(o_almost_full), 0);
    chk("t6_rd_data", int'(o_rd_data), 0);
    chk("t6_max", int'(o_max_words), 0);
    i_wr_en = 1'b1;
    i_wr_data = 16'hBEEF;
    step();
    i_wr_en = 1'b0;
    n = 0;
    for (int k = 0; k < 10 && o_empty; k++) begin
      step();
      n++;
    end
    chk("t6_lat", n, 2);
    chk("t6_data", int'(o_rd_data), 16'hBEEF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Single-clock, parametrised FIFO; general successor of the fixed 512x32 FIFO family.
- Adds configurable width and depth, first-word-fall-through (FWFT) read data, programmable almost-full and almost-empty flags, and a synchronous flush.
- Used inside one clock domain: router input buffers, DMA staging, NI command queues.
- Storage is a two-port memory with a 1-cycle registered read, followed by a single FWFT output register.

Parameters:
- DW, 32, data width in bits (1..256).
- DEPTH_LOG, 9, log2 of total capacity; capacity DEPTH = 2**DEPTH_LOG words (2..14).
- AF_RESET, 2**DEPTH_LOG-4, reset value of the almost-full threshold register (documentation only; the threshold is a port).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_flush  in  1  synchronous flush; empties the FIFO in one cycle
- i_wr_data  in  DW  write data
- i_wr_en  in  1  write request; accepted only when o_full=0
- o_full  out  1  o_words == DEPTH
- o_almost_full  out  1  o_words >= i_af_thresh
- i_af_thresh  in  DEPTH_LOG+1  almost-full threshold, quasi-static
- i_rd_en  in  1  read/pop request; accepted only when o_empty=0
- o_rd_data  out  DW  head word (FWFT); valid whenever o_empty=0
- o_empty  out  1  no word in the FWFT output register
- o_almost_empty  out  1  o_words <= i_ae_thresh
- i_ae_thresh  in  DEPTH_LOG+1  almost-empty threshold, quasi-static
- o_words  out  DEPTH_LOG+1  words stored, including the word in the output register
- o_max_words  out  DEPTH_LOG+1  high-watermark (optional feature)

Behaviour:
- All outputs are registered. Reset values:
  - o_empty=1, o_full=0, o_words=0, o_almost_empty=1, o_almost_full=0, o_rd_data=0, o_max_words=0.
  - All pointers are 0.
- Write acceptance: wr_ok = i_wr_en & ~o_full. A rejected write is dropped silently; state is unchanged.
- Read acceptance: rd_ok = i_rd_en & ~o_empty. A rejected read is ignored.
- Occupancy: o_words += wr_ok - rd_ok each cycle. Simultaneous wr_ok and rd_ok leaves the count unchanged. Capacity is exactly DEPTH; the output register does not add a slot.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG bits and wrap modulo DEPTH with no special case at wrap-around.
- Memory read: issued when (FWFT register empty or being popped) and the memory holds an unread word. The memory returns data 1 cycle later; that data loads the output register.
- Fill latency: a write at edge N into an empty FIFO gives o_empty=0 and valid o_rd_data after edge N+2. o_words=1 already after edge N.
- Streaming: with continuous rd_ok, a new head is presented every cycle, with no bubbles, as long as memory is non-empty.
- o_rd_data holds its value while o_empty=1 or while no pop occurs.
- Full:
  - o_full=1 after the edge at which o_words reaches DEPTH.
  - Simultaneous write and read while full: the read is accepted, the write is rejected.
- Empty: a simultaneous write and read while o_empty=1 accepts the write and rejects the read.
- Flags: o_almost_full and o_almost_empty are computed from the next-state count, so they are valid the same cycle as o_words.
- Flush (i_flush=1):
  - Next edge: pointers, count and flags take their reset values. o_rd_data is not cleared.
  - wr_en and rd_en in the flush cycle are ignored.
  - An in-flight memory read is discarded.
  - rst has priority over i_flush.
- Reset mid-operation: all contents are lost. The FIFO accepts writes on the first cycle after rst deasserts.

Optional Feature:
- Macro: FIFO_SYNC_WATERMARK_EN.
- Defined:
  - o_max_words is a register updated as max(o_max_words, next o_words).
  - Cleared by rst only, not by i_flush.
- Undefined:
  - o_max_words is tied to 0 and no register is synthesised.
  - The port list is identical in both builds.

Decomposition:
- Package fifo_sync_pkg holds:
  - the function for the DEPTH_LOG+1 count width;
  - the reset constants for the flags;
  - the shared flag-compare function used for the almost-full/almost-empty comparisons.
- One sub-module, fifo_sync_ptr, holds pointers, count, full/empty and almost flags.
- Top level holds memory inference (or the xil_mem_dp wrapper for DW=32, DEPTH_LOG=9) and the FWFT output stage.

Test Plan (bench uses DW=16, DEPTH_LOG=4, i_af_thresh=14, i_ae_thresh=1):
- Single write 0xA5A5 at edge 0 -> o_words=1 after edge 0; o_empty=0, o_rd_data=0xA5A5 after edge 2; pop -> o_empty=1, o_words=0.
- Write 16 words 0..15 with no reads -> o_full=1 after 16th write; o_almost_full=1 after 14th; 17th write (0xFFFF) dropped; pops return 0..15 in order.
- Full FIFO with simultaneous rd_en and wr_en(0x0100) -> the read is accepted, the write is rejected; o_words goes 16->15; 0x0100 never appears.
- Continuous write+read for 40 cycles (crosses wrap-around twice) -> each word is read exactly once, in order, with no bubbles after the initial 2-cycle fill; o_words stays constant.
- Fill to 9, assert i_flush with wr_en=1 -> o_words=0, o_empty=1, o_almost_empty=1 next cycle; subsequent write 0x1234 is read back correctly; with FIFO_SYNC_WATERMARK_EN, o_max_words stays 9.
- Assert rst while 5 words are queued and rd_en=1 -> all outputs take reset values after one edge; first post-reset write is read back correctly.
